arb8way16: RTL and testbench

Round-robin arbiter and sequencer for the shared 16-bit 8-way data mux: eight requesters compete for one registered output channel. The block computes the grant index, drives it as `sel` into an internal `Mux8Way16`, and registers the selected word into a single output slot with valid/ready handshakes on both sides. Optional bounded burst locking lets one requester keep the channel for consecutive beats. It sits between the requesting units and the single shared consumer, such as a bus or register-file write port.

---
 rtl/arb_pkg.sv | 32 +++
 rtl/arb8way16_if.sv | 26 ++
 rtl/Mux8Way16.sv | 30 +++
 rtl/arb8way16.sv | 119 +++++++++++
 tb/tb_arb8way16.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way 16-bit round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned DATA_W = 16;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid scanning ptr, ptr+1, ... ptr+7 (mod 8); the
    // downward loop leaves the smallest offset as the final winner.
    function automatic rr_pick_t rr_pick(input logic [N_REQ-1:0] valid,
                                         input logic [SEL_W-1:0] ptr);
        rr_pick_t         r;
        logic [SEL_W-1:0] cand;
        r = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (valid[cand]) begin
                r.found = 1'b1;
                r.idx   = cand;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arb8way16_if.sv
// Requester and consumer handshake bundle for arb8way16.
interface arb8way16_if;
    import arb_pkg::*;

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0]             req_lock;
    logic [N_REQ-1:0][DATA_W-1:0] req_data;
    logic [N_REQ-1:0]             req_ready;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_W-1:0]            out_data;
    logic [SEL_W-1:0]             out_src;

    // Requesters and consumer drive the bus from this side.
    modport master (
        output req_valid, req_lock, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_src
    );

    // The arbiter sits on this side.
    modport slave (
        input  req_valid, req_lock, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/Mux8Way16.sv
// Eight-input 16-bit word multiplexer.
module Mux8Way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out
);

    always_comb begin
        out = a;
        case (sel)
            3'd0:    out = a;
            3'd1:    out = b;
            3'd2:    out = c;
            3'd3:    out = d;
            3'd4:    out = e;
            3'd5:    out = f;
            3'd6:    out = g;
            3'd7:    out = h;
            default: out = a;
        endcase
    end

endmodule

// File: rtl/arb8way16.sv
// Round-robin arbiter with bounded burst locking feeding a single registered
// output slot through Mux8Way16.
module arb8way16 import arb_pkg::*; #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    arb8way16_if.slave   bus
);

    localparam int unsigned CNT_W = 4;

    arb_state_t        state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  burst_q, burst_d;
    logic [CNT_W-1:0]  cnt_inc;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [SEL_W-1:0]  out_src_q;

    logic [N_REQ-1:0]  ready_c;
    logic [SEL_W-1:0]  gidx;
    logic              slot_free;
    logic              accept;
    rr_pick_t          pick;
    logic [DATA_W-1:0] mux_out;

    assign slot_free = !out_valid_q || bus.out_ready;

    Mux8Way16 u_mux (
        .a   (bus.req_data[0]),
        .b   (bus.req_data[1]),
        .c   (bus.req_data[2]),
        .d   (bus.req_data[3]),
        .e   (bus.req_data[4]),
        .f   (bus.req_data[5]),
        .g   (bus.req_data[6]),
        .h   (bus.req_data[7]),
        .sel (gidx),
        .out (mux_out)
    );

    // Grant selection, ready generation and pointer/burst bookkeeping.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        burst_d = burst_q;
        gidx    = ptr_q;
        ready_c = '0;
        pick    = rr_pick(bus.req_valid, ptr_q);
        cnt_inc = burst_q + CNT_W'(1);

        if (state_q == ARB_IDLE) begin
            if (pick.found) begin
                gidx          = pick.idx;
                ready_c[gidx] = slot_free;
            end
        end else begin
            gidx          = owner_q;
            ready_c[gidx] = slot_free && bus.req_valid[owner_q];
        end

        accept = |(ready_c & bus.req_valid);

        if (accept) begin
            if (state_q == ARB_IDLE) begin
                if (bus.req_lock[gidx] && (MAX_BURST > 1)) begin
                    state_d = ARB_LOCKED;
                    owner_d = gidx;
                    burst_d = CNT_W'(1);
                end else begin
                    ptr_d = gidx + SEL_W'(1);
                end
            end else begin
                // Voluntary unlock or burst budget exhausted both release.
                if (!bus.req_lock[owner_q] || (cnt_inc >= CNT_W'(MAX_BURST))) begin
                    state_d = ARB_IDLE;
                    ptr_d   = owner_q + SEL_W'(1);
                    burst_d = '0;
                end else begin
                    burst_d = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            burst_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mux_out;
                out_src_q   <= gidx;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_arb8way16.sv
// Randomised scoreboard bench for arb8way16 against a rule-level arbiter model.
module tb_arb8way16;
    import arb_pkg::*;

    localparam int unsigned MAXB = 4;

    logic clk;
    logic rst_n;

    arb8way16_if bus();

    arb8way16 #(.MAX_BURST(MAXB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] data;
        int          src;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] dat[8];

    // Reference model state: plain integers, no notion of the RTL encoding.
    bit m_locked = 0;
    int m_owner  = 0;
    int m_ptr    = 0;
    int m_beats  = 0;
    bit m_ov     = 0;
    bit prev_rst = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_pick(input logic [7:0] v);
        if (m_locked) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < 8; k++) begin
            if (v[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
        end
        return -1;
    endfunction

    // One clock cycle: drive at +1, predict/check ready at +3, push expected words.
    task automatic step(input bit rst, input logic [7:0] v, input logic [7:0] lk, input bit ord);
        int          g;
        bit          acc;
        logic [7:0]  er;
        exp_t        e;
        @(posedge clk);
        #1;
        rst_n         = !rst;
        bus.req_valid = v;
        bus.req_lock  = lk;
        bus.out_ready = ord;
        for (int i = 0; i < 8; i++) bus.req_data[i] = dat[i];
        #2;
        if (prev_rst) begin
            check("reset_out_data", 32'(bus.out_data), 32'h0);
            check("reset_out_src", 32'(bus.out_src), 32'h0);
        end
        check("out_valid", 32'(bus.out_valid), 32'(m_ov));
        if (rst) begin
            sb.delete();
            m_locked = 0;
            m_ptr    = 0;
            m_beats  = 0;
            m_ov     = 0;
            prev_rst = 1;
        end else begin
            prev_rst = 0;
            g   = m_pick(v);
            acc = (g >= 0) && (!m_ov || ord);
            er  = acc ? 8'(1 << g) : 8'h00;
            check("req_ready", 32'(bus.req_ready), 32'(er));
            if (acc) begin
                e.data = dat[g];
                e.src  = g;
                sb.push_back(e);
                if (!m_locked) begin
                    if (lk[g] && MAXB > 1) begin
                        m_locked = 1;
                        m_owner  = g;
                        m_beats  = 1;
                    end else begin
                        m_ptr = (g + 1) % 8;
                    end
                end else begin
                    m_beats++;
                    if (!lk[g] || m_beats >= MAXB) begin
                        m_locked = 0;
                        m_ptr    = (m_owner + 1) % 8;
                    end
                end
            end
            m_ov = acc ? 1'b1 : (ord ? 1'b0 : m_ov);
        end
    endtask

    // Monitor: every word the consumer takes must be the oldest expected one.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual=out_src %0d expected=no word at %0t", bus.out_src, $time);
            end else if (bus.out_ready === 1'b1) begin
                e = sb.pop_front();
                check("out_data", 32'(bus.out_data), 32'(e.data));
                check("out_src", 32'(bus.out_src), 32'(e.src));
            end
        end
    end

    task automatic set_onehot_data();
        for (int i = 0; i < 8; i++) dat[i] = 16'(16'h0001 << i);
    endtask

    task automatic set_random_data();
        for (int i = 0; i < 8; i++) dat[i] = 16'($urandom);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) bus.req_data[i] = '0;
        set_onehot_data();
        repeat (2) @(posedge clk);

        // Single requester after reset.
        dat[2] = 16'h0004;
        step(0, 8'h04, 8'h00, 1);
        step(0, 8'h00, 8'h00, 1);
        step(0, 8'h00, 8'h00, 1);

        // All valid, no lock: full rotation.
        step(1, 8'h00, 8'h00, 1);
        set_onehot_data();
        repeat (9) step(0, 8'hFF, 8'h00, 1);

        // Backpressure then release.
        repeat (6) step(0, 8'hFF, 8'h00, 0);
        repeat (4) step(0, 8'hFF, 8'h00, 1);

        // Lock by requester 5 against requester 6.
        step(1, 8'h00, 8'h00, 1);
        repeat (7) step(0, 8'h60, 8'h20, 1);

        // Early unlock on the second beat of requester 1.
        step(1, 8'h00, 8'h00, 1);
        step(0, 8'h02, 8'h02, 1);
        repeat (3) step(0, 8'h0E, 8'h00, 1);

        // Reset in the middle of a burst with the slot full.
        repeat (2) step(0, 8'hFF, 8'hFF, 1);
        step(1, 8'hFF, 8'hFF, 0);
        repeat (3) step(0, 8'hFF, 8'h00, 1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            set_random_data();
            step(($urandom_range(0, 199) == 0),
                 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) != 0));
        end

        // Drain and confirm nothing is left pending.
        repeat (MAXB + 3) step(0, 8'h00, 8'h00, 1);
        @(posedge clk);
        #3;
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
